axi4_lite_slave_regs: RTL and testbench

- AXI4-Lite slave (responder) exposing a bank of NREG read/write registers to an AXI-Lite master.
- Accepts write address and write data independently, in either order or together, and honours WSTRB byte lanes.
- Returns OKAY for in-range accesses and SLVERR for out-of-range ones.
- Presents register contents and one-cycle write pulses to user logic; sits at the slave end of the codebase's AXI-Lite master.

---
 rtl/axi4_lite_slave_regs.sv | 195 +++++++++++++++++++
 tb/tb_axi4_lite_slave_regs.sv | 330 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi4_lite_slave_regs.sv
// AXI4-Lite responder exposing NREG 32-bit registers with byte-strobe writes,
// per-register write pulses, and independent read/write channel FSMs.
module axi4_lite_slave_regs #(
    parameter int DW   = 32,
    parameter int AW   = 32,
    parameter int NREG = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [AW-1:0]        AXI_AWADDR,
    input  logic                 AXI_AWVALID,
    output logic                 AXI_AWREADY,
    input  logic [DW-1:0]        AXI_WDATA,
    input  logic [DW/8-1:0]      AXI_WSTRB,
    input  logic                 AXI_WVALID,
    output logic                 AXI_WREADY,
    output logic [1:0]           AXI_BRESP,
    output logic                 AXI_BVALID,
    input  logic                 AXI_BREADY,
    input  logic [AW-1:0]        AXI_ARADDR,
    input  logic                 AXI_ARVALID,
    output logic                 AXI_ARREADY,
    output logic [DW-1:0]        AXI_RDATA,
    output logic [1:0]           AXI_RRESP,
    output logic                 AXI_RVALID,
    input  logic                 AXI_RREADY,
    output logic [NREG*DW-1:0]   REG_OUT,
    output logic [NREG-1:0]      WR_PULSE
);
    localparam int IW = AW - 2;

    typedef enum logic {W_COLLECT, W_RESP} wstate_t;
    typedef enum logic {R_IDLE, R_DATA} rstate_t;

    wstate_t              r_wstate, w_wstate_nxt;
    rstate_t              r_rstate, w_rstate_nxt;

    logic [DW-1:0]        r_regs [NREG];
    logic [NREG-1:0]      r_wr_pulse;
    logic                 r_awready, r_wready, r_arready;
    logic                 r_aw_held, r_w_held;
    logic [IW-1:0]        r_awidx;
    logic [DW-1:0]        r_wdata;
    logic [DW/8-1:0]      r_wstrb;
    logic                 r_bvalid, r_rvalid;
    logic [1:0]           r_bresp, r_rresp;
    logic [DW-1:0]        r_rdata;

    logic                 w_aw_hs, w_w_hs, w_ar_hs, w_commit, w_win, w_rin;
    logic [IW-1:0]        w_widx, w_ridx;
    logic [DW-1:0]        w_wdat, w_rd_val;
    logic [DW/8-1:0]      w_wstb;
    logic                 w_unused_addr;

    assign w_unused_addr = ^{AXI_AWADDR[1:0], AXI_ARADDR[1:0]};

    // Extra MSB lets NREG == 2^IW compare without overflow.
    function automatic logic in_range(input logic [IW-1:0] idx);
        return {1'b0, idx} < (IW+1)'(NREG);
    endfunction

    // Write FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_wstate <= W_COLLECT;
        else       r_wstate <= w_wstate_nxt;
    end

    // Write FSM: next state
    always_comb begin
        w_wstate_nxt = r_wstate;
        case (r_wstate)
            W_COLLECT: if (w_commit)   w_wstate_nxt = W_RESP;
            W_RESP:    if (AXI_BREADY) w_wstate_nxt = W_COLLECT;
            default:                   w_wstate_nxt = W_COLLECT;
        endcase
    end

    // Write FSM: outputs; a channel handshaking this edge bypasses its holding register
    always_comb begin
        w_aw_hs  = AXI_AWVALID & r_awready;
        w_w_hs   = AXI_WVALID & r_wready;
        w_widx   = w_aw_hs ? AXI_AWADDR[AW-1:2] : r_awidx;
        w_wdat   = w_w_hs ? AXI_WDATA : r_wdata;
        w_wstb   = w_w_hs ? AXI_WSTRB : r_wstrb;
        w_win    = in_range(w_widx);
        w_commit = (r_wstate == W_COLLECT) & (r_aw_held | w_aw_hs) & (r_w_held | w_w_hs);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_awready  <= 1'b0;
            r_wready   <= 1'b0;
            r_aw_held  <= 1'b0;
            r_w_held   <= 1'b0;
            r_awidx    <= '0;
            r_wdata    <= '0;
            r_wstrb    <= '0;
            r_bvalid   <= 1'b0;
            r_bresp    <= 2'b00;
            r_wr_pulse <= '0;
            for (int i = 0; i < NREG; i++) r_regs[i] <= '0;
        end else begin
            for (int i = 0; i < NREG; i++) begin
                r_wr_pulse[i] <= w_commit & w_win & (w_widx == IW'(i));
                if (w_commit && w_win && w_widx == IW'(i))
                    for (int b = 0; b < DW/8; b++)
                        if (w_wstb[b]) r_regs[i][8*b +: 8] <= w_wdat[8*b +: 8];
            end
            if (w_aw_hs) r_awidx <= AXI_AWADDR[AW-1:2];
            if (w_w_hs) begin
                r_wdata <= AXI_WDATA;
                r_wstrb <= AXI_WSTRB;
            end
            if (r_wstate == W_COLLECT) begin
                if (w_commit) begin
                    r_awready <= 1'b0;
                    r_wready  <= 1'b0;
                    r_aw_held <= 1'b0;
                    r_w_held  <= 1'b0;
                    r_bvalid  <= 1'b1;
                    r_bresp   <= w_win ? 2'b00 : 2'b10;
                end else begin
                    r_aw_held <= r_aw_held | w_aw_hs;
                    r_w_held  <= r_w_held | w_w_hs;
                    r_awready <= ~(r_aw_held | w_aw_hs);
                    r_wready  <= ~(r_w_held | w_w_hs);
                end
            end else if (AXI_BREADY) begin
                r_bvalid  <= 1'b0;
                r_awready <= 1'b1;
                r_wready  <= 1'b1;
            end
        end
    end

    // Read FSM: state register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_rstate <= R_IDLE;
        else       r_rstate <= w_rstate_nxt;
    end

    // Read FSM: next state
    always_comb begin
        w_rstate_nxt = r_rstate;
        case (r_rstate)
            R_IDLE:  if (w_ar_hs)    w_rstate_nxt = R_DATA;
            R_DATA:  if (AXI_RREADY) w_rstate_nxt = R_IDLE;
            default:                 w_rstate_nxt = R_IDLE;
        endcase
    end

    // Read FSM: outputs
    always_comb begin
        w_ar_hs  = AXI_ARVALID & r_arready & (r_rstate == R_IDLE);
        w_ridx   = AXI_ARADDR[AW-1:2];
        w_rin    = in_range(w_ridx);
        w_rd_val = '0;
        for (int i = 0; i < NREG; i++)
            if (w_ridx == IW'(i)) w_rd_val = r_regs[i];
    end

    // Reads sample r_regs before any same-edge write lands.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_arready <= 1'b0;
            r_rvalid  <= 1'b0;
            r_rdata   <= '0;
            r_rresp   <= 2'b00;
        end else if (r_rstate == R_IDLE) begin
            r_arready <= ~w_ar_hs;
            if (w_ar_hs) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rin ? w_rd_val : '0;
                r_rresp  <= w_rin ? 2'b00 : 2'b10;
            end
        end else if (AXI_RREADY) begin
            r_rvalid  <= 1'b0;
            r_arready <= 1'b1;
        end
    end

    for (genvar g = 0; g < NREG; g++) begin : g_reg_out
        assign REG_OUT[g*DW +: DW] = r_regs[g];
    end

    assign AXI_AWREADY = r_awready;
    assign AXI_WREADY  = r_wready;
    assign AXI_BVALID  = r_bvalid;
    assign AXI_BRESP   = r_bresp;
    assign AXI_ARREADY = r_arready;
    assign AXI_RVALID  = r_rvalid;
    assign AXI_RDATA   = r_rdata;
    assign AXI_RRESP   = r_rresp;
    assign WR_PULSE    = r_wr_pulse;
endmodule

// File: tb/tb_axi4_lite_slave_regs.sv
// Directed self-checking bench for axi4_lite_slave_regs (NREG=16, 32-bit).
module tb_axi4_lite_slave_regs;
    localparam int DW = 32, AW = 32, NREG = 16;

    logic clk = 1'b0, reset = 1'b1;
    logic [AW-1:0] AXI_AWADDR = '0, AXI_ARADDR = '0;
    logic AXI_AWVALID = 0, AXI_WVALID = 0, AXI_BREADY = 0, AXI_ARVALID = 0, AXI_RREADY = 0;
    logic [DW-1:0] AXI_WDATA = '0;
    logic [3:0] AXI_WSTRB = '0;
    logic AXI_AWREADY, AXI_WREADY, AXI_BVALID, AXI_ARREADY, AXI_RVALID;
    logic [1:0] AXI_BRESP, AXI_RRESP;
    logic [DW-1:0] AXI_RDATA;
    logic [NREG*DW-1:0] REG_OUT;
    logic [NREG-1:0] WR_PULSE;

    int errors = 0, checks = 0;
    logic [31:0] exp_regs [NREG];
    logic [NREG-1:0] pulse_acc = '0;

    always #5 clk = ~clk;
    always @(negedge clk) pulse_acc <= pulse_acc | WR_PULSE;

    axi4_lite_slave_regs #(.DW(DW), .AW(AW), .NREG(NREG)) dut (
        .clk(clk), .reset(reset),
        .AXI_AWADDR(AXI_AWADDR), .AXI_AWVALID(AXI_AWVALID), .AXI_AWREADY(AXI_AWREADY),
        .AXI_WDATA(AXI_WDATA), .AXI_WSTRB(AXI_WSTRB), .AXI_WVALID(AXI_WVALID), .AXI_WREADY(AXI_WREADY),
        .AXI_BRESP(AXI_BRESP), .AXI_BVALID(AXI_BVALID), .AXI_BREADY(AXI_BREADY),
        .AXI_ARADDR(AXI_ARADDR), .AXI_ARVALID(AXI_ARVALID), .AXI_ARREADY(AXI_ARREADY),
        .AXI_RDATA(AXI_RDATA), .AXI_RRESP(AXI_RRESP), .AXI_RVALID(AXI_RVALID), .AXI_RREADY(AXI_RREADY),
        .REG_OUT(REG_OUT), .WR_PULSE(WR_PULSE)
    );

    function automatic logic [31:0] dut_reg(input int i);
        return REG_OUT[i*DW +: DW];
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Full write transaction; ok=0 if any phase exceeds its cycle budget.
    task automatic axi_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                             output logic [1:0] resp, output bit ok);
        bit aw_hs, w_hs;
        ok = 0;
        resp = 2'b11;
        AXI_AWADDR = a; AXI_WDATA = d; AXI_WSTRB = s;
        AXI_AWVALID = 1; AXI_WVALID = 1;
        for (int c = 0; c < 20 && (AXI_AWVALID || AXI_WVALID); c++) begin
            @(negedge clk);
            aw_hs = AXI_AWVALID && AXI_AWREADY;
            w_hs  = AXI_WVALID && AXI_WREADY;
            tick();
            if (aw_hs) AXI_AWVALID = 0;
            if (w_hs)  AXI_WVALID = 0;
        end
        if (AXI_AWVALID || AXI_WVALID) begin
            AXI_AWVALID = 0; AXI_WVALID = 0;
            return;
        end
        AXI_BREADY = 1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (AXI_BVALID) begin
                resp = AXI_BRESP;
                ok = 1;
            end
            tick();
        end
        AXI_BREADY = 0;
    endtask

    task automatic axi_read(input logic [31:0] a, output logic [31:0] data,
                            output logic [1:0] resp, output bit ok);
        bit ar_hs = 0;
        ok = 0;
        data = '1;
        resp = 2'b11;
        AXI_ARADDR = a; AXI_ARVALID = 1;
        for (int c = 0; c < 20 && !ar_hs; c++) begin
            @(negedge clk);
            ar_hs = AXI_ARREADY;
            tick();
        end
        AXI_ARVALID = 0;
        if (!ar_hs) return;
        AXI_RREADY = 1;
        for (int c = 0; c < 20 && !ok; c++) begin
            @(negedge clk);
            if (AXI_RVALID) begin
                data = AXI_RDATA; resp = AXI_RRESP; ok = 1;
            end
            tick();
        end
        AXI_RREADY = 0;
    endtask

    task automatic test_reset();
        reset = 1;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID} !== 5'b0) begin
            errors++; $display("FAIL reset_ctrl got %b want 00000",
                {AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID});
        end
        checks++;
        if ({AXI_BRESP, AXI_RRESP, AXI_RDATA} !== 36'h0 || REG_OUT !== '0 || WR_PULSE !== '0) begin
            errors++; $display("FAIL reset_data got resp %b/%b rdata %h pulse %h want all zero",
                AXI_BRESP, AXI_RRESP, AXI_RDATA, WR_PULSE);
        end
        reset = 0;
        tick();
        checks++;
        if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY} !== 3'b111) begin
            errors++; $display("FAIL reset_release_ready got %b want 111",
                {AXI_AWREADY, AXI_WREADY, AXI_ARREADY});
        end
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
    endtask

    task automatic test_same_edge();
        AXI_AWADDR = 32'h08; AXI_WDATA = 32'hDEADBEEF; AXI_WSTRB = 4'hF;
        AXI_AWVALID = 1; AXI_WVALID = 1;
        tick();
        AXI_AWVALID = 0; AXI_WVALID = 0;
        exp_regs[2] = 32'hDEADBEEF;
        checks++;
        if (dut_reg(2) !== 32'hDEADBEEF) begin
            errors++; $display("FAIL same_edge_reg2 got %h want deadbeef", dut_reg(2));
        end
        checks++;
        if (WR_PULSE !== 16'h0004) begin
            errors++; $display("FAIL same_edge_pulse got %h want 0004", WR_PULSE);
        end
        checks++;
        if ({AXI_BVALID, AXI_BRESP, AXI_AWREADY, AXI_WREADY} !== 5'b10000) begin
            errors++; $display("FAIL same_edge_b got %b want 10000",
                {AXI_BVALID, AXI_BRESP, AXI_AWREADY, AXI_WREADY});
        end
        tick();
        checks++;
        if (WR_PULSE !== '0 || AXI_BVALID !== 1'b1 || AXI_AWREADY !== 1'b0) begin
            errors++; $display("FAIL same_edge_hold got pulse %h bvalid %b awready %b want 0000 1 0",
                WR_PULSE, AXI_BVALID, AXI_AWREADY);
        end
        AXI_BREADY = 1;
        tick();
        AXI_BREADY = 0;
        checks++;
        if ({AXI_BVALID, AXI_AWREADY, AXI_WREADY} !== 3'b011) begin
            errors++; $display("FAIL same_edge_bdone got %b want 011",
                {AXI_BVALID, AXI_AWREADY, AXI_WREADY});
        end
    endtask

    task automatic test_w_before_aw();
        AXI_WDATA = 32'h12345678; AXI_WSTRB = 4'hF; AXI_WVALID = 1;
        tick();
        AXI_WVALID = 0;
        for (int c = 0; c < 3; c++) begin
            checks++;
            if (AXI_WREADY !== 1'b0 || AXI_AWREADY !== 1'b1 || AXI_BVALID !== 1'b0) begin
                errors++; $display("FAIL w_first_wait%0d got wready %b awready %b bvalid %b want 0 1 0",
                    c, AXI_WREADY, AXI_AWREADY, AXI_BVALID);
            end
            if (c < 2) tick();
        end
        AXI_AWADDR = 32'h04; AXI_AWVALID = 1;
        tick();
        AXI_AWVALID = 0;
        exp_regs[1] = 32'h12345678;
        checks++;
        if (dut_reg(1) !== 32'h12345678 || WR_PULSE !== 16'h0002 || AXI_BVALID !== 1'b1) begin
            errors++; $display("FAIL w_first_commit got reg1 %h pulse %h bvalid %b want 12345678 0002 1",
                dut_reg(1), WR_PULSE, AXI_BVALID);
        end
        AXI_BREADY = 1;
        tick();
        AXI_BREADY = 0;
    endtask

    task automatic test_strobe();
        logic [1:0] r; bit ok;
        axi_write(32'h0C, 32'hAABBCCDD, 4'hF, r, ok);
        axi_write(32'h0C, 32'h11223344, 4'h5, r, ok);
        exp_regs[3] = 32'hAA22CC44;
        checks++;
        if (!ok || r !== 2'b00 || dut_reg(3) !== 32'hAA22CC44) begin
            errors++; $display("FAIL strobe got ok %0d resp %b reg3 %h want 1 00 aa22cc44",
                ok, r, dut_reg(3));
        end
        axi_write(32'h0C, 32'h99999999, 4'h0, r, ok);
        checks++;
        if (!ok || dut_reg(3) !== 32'hAA22CC44 || pulse_acc[3] !== 1'b1) begin
            errors++; $display("FAIL strobe_zero got ok %0d reg3 %h pulse3 %b want 1 aa22cc44 1",
                ok, dut_reg(3), pulse_acc[3]);
        end
    endtask

    task automatic test_out_of_range();
        logic [1:0] r; logic [31:0] d; bit ok, same;
        pulse_acc = '0;
        axi_write(32'h40, 32'hCAFEF00D, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 2'b10 || pulse_acc !== '0) begin
            errors++; $display("FAIL oor_write got ok %0d resp %b pulses %h want 1 10 0000", ok, r, pulse_acc);
        end
        same = 1;
        for (int i = 0; i < NREG; i++) if (dut_reg(i) !== exp_regs[i]) same = 0;
        checks++;
        if (!same) begin
            errors++; $display("FAIL oor_regs got %h want reg3 %h reg2 %h", REG_OUT, exp_regs[3], exp_regs[2]);
        end
        axi_read(32'h40, d, r, ok);
        checks++;
        if (!ok || d !== 32'h0 || r !== 2'b10) begin
            errors++; $display("FAIL oor_read got ok %0d data %h resp %b want 1 00000000 10", ok, d, r);
        end
    endtask

    task automatic test_read_stall();
        AXI_ARADDR = 32'h08; AXI_ARVALID = 1;
        tick();
        AXI_ARVALID = 0;
        for (int c = 0; c < 5; c++) begin
            checks++;
            if (AXI_RVALID !== 1'b1 || AXI_RDATA !== 32'hDEADBEEF || AXI_RRESP !== 2'b00 || AXI_ARREADY !== 1'b0) begin
                errors++; $display("FAIL rd_stall%0d got rvalid %b rdata %h rresp %b arready %b want 1 deadbeef 00 0",
                    c, AXI_RVALID, AXI_RDATA, AXI_RRESP, AXI_ARREADY);
            end
            tick();
        end
        AXI_RREADY = 1;
        tick();
        AXI_RREADY = 0;
        checks++;
        if (AXI_RVALID !== 1'b0 || AXI_ARREADY !== 1'b1) begin
            errors++; $display("FAIL rd_done got rvalid %b arready %b want 0 1", AXI_RVALID, AXI_ARREADY);
        end
    endtask

    task automatic test_back_to_back();
        AXI_BREADY = 1;
        AXI_AWADDR = 32'h10; AXI_WDATA = 32'hA0A0A0A0; AXI_WSTRB = 4'hF;
        AXI_AWVALID = 1; AXI_WVALID = 1;
        tick();
        checks++;
        if (WR_PULSE !== 16'h0010 || dut_reg(4) !== 32'hA0A0A0A0) begin
            errors++; $display("FAIL b2b_first got pulse %h reg4 %h want 0010 a0a0a0a0", WR_PULSE, dut_reg(4));
        end
        AXI_AWADDR = 32'h14; AXI_WDATA = 32'hB1B1B1B1;
        tick();
        tick();
        AXI_AWVALID = 0; AXI_WVALID = 0; AXI_BREADY = 0;
        exp_regs[4] = 32'hA0A0A0A0; exp_regs[5] = 32'hB1B1B1B1;
        checks++;
        if (WR_PULSE !== 16'h0020 || dut_reg(5) !== 32'hB1B1B1B1 || AXI_BVALID !== 1'b1) begin
            errors++; $display("FAIL b2b_second got pulse %h reg5 %h bvalid %b want 0020 b1b1b1b1 1",
                WR_PULSE, dut_reg(5), AXI_BVALID);
        end
        AXI_BREADY = 1;
        tick();
        AXI_BREADY = 0;
    endtask

    task automatic test_read_during_write();
        AXI_AWADDR = 32'h10; AXI_WDATA = 32'hC3C3C3C3; AXI_WSTRB = 4'hF;
        AXI_AWVALID = 1; AXI_WVALID = 1;
        AXI_ARADDR = 32'h10; AXI_ARVALID = 1;
        tick();
        AXI_AWVALID = 0; AXI_WVALID = 0; AXI_ARVALID = 0;
        exp_regs[4] = 32'hC3C3C3C3;
        checks++;
        if (AXI_RVALID !== 1'b1 || AXI_RDATA !== 32'hA0A0A0A0 || dut_reg(4) !== 32'hC3C3C3C3) begin
            errors++; $display("FAIL rw_same_edge got rvalid %b rdata %h reg4 %h want 1 a0a0a0a0 c3c3c3c3",
                AXI_RVALID, AXI_RDATA, dut_reg(4));
        end
        AXI_BREADY = 1; AXI_RREADY = 1;
        tick();
        AXI_BREADY = 0; AXI_RREADY = 0;
    endtask

    task automatic test_reset_mid_write();
        logic [1:0] r; bit ok;
        AXI_AWADDR = 32'h18; AXI_AWVALID = 1;
        tick();
        AXI_AWVALID = 0;
        checks++;
        if (AXI_AWREADY !== 1'b0 || AXI_WREADY !== 1'b1) begin
            errors++; $display("FAIL mid_aw_taken got awready %b wready %b want 0 1", AXI_AWREADY, AXI_WREADY);
        end
        reset = 1;
        #1;
        checks++;
        if (REG_OUT !== '0 || {AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID} !== 5'b0) begin
            errors++; $display("FAIL mid_reset got reg4 %h ctrl %b want 0 00000", dut_reg(4),
                {AXI_AWREADY, AXI_WREADY, AXI_ARREADY, AXI_BVALID, AXI_RVALID});
        end
        tick();
        reset = 0;
        for (int i = 0; i < NREG; i++) exp_regs[i] = '0;
        tick();
        checks++;
        if ({AXI_AWREADY, AXI_WREADY, AXI_ARREADY} !== 3'b111) begin
            errors++; $display("FAIL mid_release got %b want 111", {AXI_AWREADY, AXI_WREADY, AXI_ARREADY});
        end
        axi_write(32'h18, 32'h5A5A5A5A, 4'hF, r, ok);
        checks++;
        if (!ok || r !== 2'b00 || dut_reg(6) !== 32'h5A5A5A5A || dut_reg(2) !== 32'h0) begin
            errors++; $display("FAIL mid_fresh got ok %0d resp %b reg6 %h reg2 %h want 1 00 5a5a5a5a 0",
                ok, r, dut_reg(6), dut_reg(2));
        end
    endtask

    initial begin
        test_reset();
        test_same_edge();
        test_w_before_aw();
        test_strobe();
        test_out_of_range();
        test_read_stall();
        test_back_to_back();
        test_read_during_write();
        test_reset_mid_write();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
